// File: rtl/mtm_alu_serializer.sv
// ALU output serializer: frames C/CTL into 11-bit packets on the idle-high line sout.
// Optional macro MTM_SER_PKT_GAP_EN inserts one idle bit between packets of a frame.
module mtm_alu_serializer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] C,
  input  logic [7:0]  CTL,
  output logic        sout,
  output logic        busy
);

  localparam logic [7:0] PRESC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] CTL_PKT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TYPE,
    S_DATA,
`ifdef MTM_SER_PKT_GAP_EN
    S_GAP,
`endif
    S_STOP
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  presc_reg, presc_next;
  logic [2:0]  bit_reg, bit_next;
  logic [2:0]  pkt_reg, pkt_next;
  logic [31:0] c_reg;
  logic [7:0]  ctl_reg;
  logic        sout_reg, sout_next;
  logic        tick;
  logic        accept;
  logic [7:0]  pkt_byte [8];

  // Packets 0..3 carry C MSB-first; every higher index maps to the control byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pkt_byte
    if (gi < 4) begin : g_data
      assign pkt_byte[gi] = c_reg[31 - 8*gi -: 8];
    end else begin : g_ctl
      assign pkt_byte[gi] = ctl_reg;
    end
  end

  assign tick     = (presc_reg == PRESC_LAST);
  assign in_ready = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);
  assign accept   = in_valid && (state_reg == S_IDLE);
  assign sout     = sout_reg;

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    bit_next   = bit_reg;
    pkt_next   = pkt_reg;
    if (state_reg == S_IDLE) begin
      presc_next = 8'd0;
      if (in_valid) begin
        state_next = S_START;
        bit_next   = 3'd0;
        pkt_next   = CTL[7] ? CTL_PKT : 3'd0;
      end
    end else begin
      presc_next = tick ? 8'd0 : presc_reg + 8'd1;
      if (tick) begin
        case (state_reg)
          S_START: state_next = S_TYPE;
          S_TYPE: begin
            state_next = S_DATA;
            bit_next   = 3'd7;
          end
          S_DATA: begin
            if (bit_reg == 3'd0) state_next = S_STOP;
            else                 bit_next   = bit_reg - 3'd1;
          end
          S_STOP: begin
            if (pkt_reg == CTL_PKT) begin
              state_next = S_IDLE;
              pkt_next   = 3'd0;
            end else begin
`ifdef MTM_SER_PKT_GAP_EN
              state_next = S_GAP;
`else
              state_next = S_START;
              pkt_next   = pkt_reg + 3'd1;
`endif
            end
          end
`ifdef MTM_SER_PKT_GAP_EN
          S_GAP: begin
            state_next = S_START;
            pkt_next   = pkt_reg + 3'd1;
          end
`endif
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  // Line level is derived from the upcoming state so that sout is a pure flop.
  always_comb begin
    sout_next = 1'b1;
    case (state_next)
      S_START: sout_next = 1'b0;
      S_TYPE:  sout_next = (pkt_next == CTL_PKT);
      S_DATA:  sout_next = pkt_byte[pkt_next][bit_next];
      default: sout_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      presc_reg <= 8'd0;
      bit_reg   <= 3'd0;
      pkt_reg   <= 3'd0;
      c_reg     <= 32'd0;
      ctl_reg   <= 8'd0;
      sout_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      bit_reg   <= bit_next;
      pkt_reg   <= pkt_next;
      sout_reg  <= sout_next;
      if (accept) begin
        c_reg   <= C;
        ctl_reg <= CTL;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench for mtm_alu_serializer: two instances (BIT_CYCLES 1 and 3), packet monitors.
module tb_mtm_alu_serializer;

`ifdef MTM_SER_PKT_GAP_EN
  localparam int FB     = 59;
  localparam int RST_AT = 32;
`else
  localparam int FB     = 55;
  localparam int RST_AT = 30;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid1, in_ready1, sout1, busy1;
  logic [31:0] c1;
  logic [7:0]  ctl1;
  logic        in_valid3, in_ready3, sout3, busy3;
  logic [31:0] c3;
  logic [7:0]  ctl3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_q0 [$];
  logic [10:0] exp_q1 [$];

  always #5 clk = ~clk;

  mtm_alu_serializer #(.BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .C(c1), .CTL(ctl1), .sout(sout1), .busy(busy1)
  );

  mtm_alu_serializer #(.BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .C(c3), .CTL(ctl3), .sout(sout3), .busy(busy3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic sout_of(input int s);
    return (s == 0) ? sout1 : sout3;
  endfunction
  function automatic logic ready_of(input int s);
    return (s == 0) ? in_ready1 : in_ready3;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? busy1 : busy3;
  endfunction

  // Receiver: decodes one 11-bit packet per start bit, checks bit hold time, pops the scoreboard.
  task automatic monitor(input int s, input int bc);
    logic [10:0] pkt;
    logic [10:0] exp;
    logic        held_ok;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (rst || sout_of(s)) continue;
      pkt = '0;
      held_ok = 1'b1;
      aborted = 1'b0;
      for (int b = 0; b < 11 && !aborted; b++) begin
        for (int k = 0; k < bc && !aborted; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (rst) aborted = 1'b1;
          else if (k == 0) pkt[10-b] = sout_of(s);
          else if (sout_of(s) != pkt[10-b]) held_ok = 1'b0;
        end
      end
      if (aborted) continue;
      if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        $display("FAIL pkt_unexpected dut%0d: got packet 0x%0h expected none", s, pkt);
      end else begin
        exp = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        $display("dut%0d packet 0x%03h expected 0x%03h held_ok=%0b", s, pkt, exp, held_ok);
        check($sformatf("pkt_dut%0d", s), {held_ok, pkt}, {1'b1, exp});
      end
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 3);

  // Called just after the accept edge; counts cycles until in_ready returns.
  task automatic wait_frame(input int s, input int exp_bits, input string nm);
    int n;
    int nb;
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({nm, "_first_start_bit"}, sout_of(s), 1'b0);
      if (busy_of(s)) nb++;
    end while (!ready_of(s) && n < 1000);
    check({nm, "_ready_latency"}, n, exp_bits + 1);
    check({nm, "_busy_cycles"}, nb, exp_bits);
    $display("%s: in_ready after %0d cycles, busy %0d cycles", nm, n, nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid1 = 1'b0; c1 = '0; ctl1 = '0;
    in_valid3 = 1'b0; c3 = '0; ctl3 = '0;
    repeat (3) @(negedge clk);
    check("reset_dut1", {sout1, in_ready1, busy1}, 3'b110);
    check("reset_dut3", {sout3, in_ready3, busy3}, 3'b110);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_dut1", {sout1, in_ready1, busy1}, 3'b110);
      check("idle_dut3", {sout3, in_ready3, busy3}, 3'b110);
    end

    // Normal frame, BIT_CYCLES=1
    c1 = 32'h12345678; ctl1 = 8'h0A; in_valid1 = 1'b1;
    exp_q0.push_back(11'b0_0_00010010_1);
    exp_q0.push_back(11'b0_0_00110100_1);
    exp_q0.push_back(11'b0_0_01010110_1);
    exp_q0.push_back(11'b0_0_01111000_1);
    exp_q0.push_back(11'b0_1_00001010_1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    wait_frame(0, FB, "normal");
    repeat (2) @(negedge clk);

    // Error frame: control packet only
    c1 = 32'hFFFFFFFF; ctl1 = 8'h93; in_valid1 = 1'b1;
    exp_q0.push_back(11'b0_1_10010011_1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    wait_frame(0, 11, "error");
    repeat (2) @(negedge clk);

    // BIT_CYCLES=3 instance
    c3 = 32'h00000000; ctl3 = 8'h24; in_valid3 = 1'b1;
    repeat (4) exp_q1.push_back(11'b0_0_00000000_1);
    exp_q1.push_back(11'b0_1_00100100_1);
    @(posedge clk); #1 in_valid3 = 1'b0;
    wait_frame(1, 3 * FB, "bc3");
    repeat (2) @(negedge clk);

    // in_valid held high, inputs changed mid-frame
    c1 = 32'h12345678; ctl1 = 8'h0A; in_valid1 = 1'b1;
    exp_q0.push_back(11'b0_0_00010010_1);
    exp_q0.push_back(11'b0_0_00110100_1);
    exp_q0.push_back(11'b0_0_01010110_1);
    exp_q0.push_back(11'b0_0_01111000_1);
    exp_q0.push_back(11'b0_1_00001010_1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 20) begin
        c1 = 32'hDEADBEEF; ctl1 = 8'h3C;
        exp_q0.push_back(11'b0_0_11011110_1);
        exp_q0.push_back(11'b0_0_10101101_1);
        exp_q0.push_back(11'b0_0_10111110_1);
        exp_q0.push_back(11'b0_0_11101111_1);
        exp_q0.push_back(11'b0_1_00111100_1);
      end
    end while (!in_ready1 && n < 1000);
    check("held_first_latency", n, FB + 1);
    check("held_gap_idle", sout1, 1'b1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    wait_frame(0, FB, "held_second");
    repeat (2) @(negedge clk);

    // Reset during the third data packet
    c1 = 32'hCAFEF00D; ctl1 = 8'h11; in_valid1 = 1'b1;
    exp_q0.push_back(11'b0_0_11001010_1);
    exp_q0.push_back(11'b0_0_11111110_1);
    exp_q0.push_back(11'b0_0_11110000_1);
    exp_q0.push_back(11'b0_0_00001101_1);
    exp_q0.push_back(11'b0_1_00010001_1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    repeat (RST_AT) @(negedge clk);
    check("pre_reset_bit", sout1, 1'b0);
    rst = 1'b1;
    #1 check("reset_async_sout", {sout1, in_ready1, busy1}, 3'b110);
    repeat (2) @(negedge clk);
    exp_q0.delete();
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {sout1, in_ready1, busy1}, 3'b110);
    c1 = 32'hA5C30F96; ctl1 = 8'h42; in_valid1 = 1'b1;
    exp_q0.push_back(11'b0_0_10100101_1);
    exp_q0.push_back(11'b0_0_11000011_1);
    exp_q0.push_back(11'b0_0_00001111_1);
    exp_q0.push_back(11'b0_0_10010110_1);
    exp_q0.push_back(11'b0_1_01000010_1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    wait_frame(0, FB, "post_reset");
    repeat (3) @(negedge clk);

    check("scoreboard_empty_dut1", exp_q0.size(), 0);
    check("scoreboard_empty_dut3", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
